// File: rtl/string_led_pkg.sv
// Shared state encoding, pixel width and default 40 MHz timing for the
// string LED serializer.
package string_led_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BIT   = 2'd1,
      LATCH = 2'd2
   } state_e;

   localparam int unsigned PIXEL_W  = 24;
   localparam int unsigned BITCNT_W = $clog2(PIXEL_W);

   localparam int unsigned T0H_DEF    = 14;
   localparam int unsigned T1H_DEF    = 28;
   localparam int unsigned PERIOD_DEF = 50;
   localparam int unsigned LATCH_DEF  = 12000;

endpackage

// File: rtl/string_led_bit_timer.sv
// Per-bit cycle counter: end-of-period strobe and the high-time compare
// that shapes each NRZ bit.
module string_led_bit_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_i,
   input  logic [CNT_W-1:0] period_i,
   input  logic [CNT_W-1:0] th_i,
   output logic             end_o,
   output logic             hi_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter idles at zero so every entry into BIT starts a fresh period.
   always_comb begin
      end_o = run_i && (cnt_q == (period_i - CNT_W'(1)));
      hi_o  = (cnt_q < th_i);
      cnt_d = (!run_i || end_o) ? '0 : (cnt_q + CNT_W'(1));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/string_led_serializer.sv
// GRB pixel stream to WS2812-style single-wire NRZ serializer with
// runtime bit timing and a post-frame latch gap.
module string_led_serializer
   import string_led_pkg::*;
#(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned LATCH_W = 16
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic [CNT_W-1:0]   cfg_t0h,
   input  logic [CNT_W-1:0]   cfg_t1h,
   input  logic [CNT_W-1:0]   cfg_period,
   input  logic [LATCH_W-1:0] cfg_latch,
   input  logic               pix_valid,
   output logic               pix_ready,
   input  logic [PIXEL_W-1:0] pix_data,
   input  logic               pix_last,
   output logic               led_dout,
   output logic               busy,
   output logic               frame_done,
   output logic               underrun
);

   state_e               state_q, state_d;
   logic [PIXEL_W-1:0]   sh_q, sh_d;
   logic [BITCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic                 last_q, last_d;
   logic [CNT_W-1:0]     t0h_q, t0h_d, t1h_q, t1h_d, per_q, per_d;
   logic [LATCH_W-1:0]   lat_q, lat_d, lcnt_q, lcnt_d;
   logic                 led_q, led_d, done_q, done_d, urun_q, urun_d;

   logic                 bit_end, bit_hi;
   logic [CNT_W-1:0]     th_sel;

   assign th_sel = sh_q[PIXEL_W-1] ? t1h_q : t0h_q;

   string_led_bit_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .run_i    (state_q == BIT),
      .period_i (per_q),
      .th_i     (th_sel),
      .end_o    (bit_end),
      .hi_o     (bit_hi)
   );

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      bit_cnt_d = bit_cnt_q;
      last_d    = last_q;
      t0h_d     = t0h_q;
      t1h_d     = t1h_q;
      per_d     = per_q;
      lat_d     = lat_q;
      lcnt_d    = lcnt_q;
      led_d     = 1'b0;
      done_d    = 1'b0;
      urun_d    = 1'b0;
      pix_ready = 1'b0;
      unique case (state_q)
         IDLE: begin
            pix_ready = 1'b1;
            if (pix_valid) begin
               sh_d      = pix_data;
               bit_cnt_d = BITCNT_W'(PIXEL_W - 1);
               last_d    = pix_last;
               t0h_d     = cfg_t0h;
               t1h_d     = cfg_t1h;
               per_d     = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;
               lat_d     = (cfg_latch == '0) ? LATCH_W'(1) : cfg_latch;
               state_d   = BIT;
            end
         end
         BIT: begin
            led_d = bit_hi;
            if (bit_end) begin
               if (bit_cnt_q != '0) begin
                  sh_d      = {sh_q[PIXEL_W-2:0], 1'b0};
                  bit_cnt_d = bit_cnt_q - BITCNT_W'(1);
               end else if (last_q) begin
                  lcnt_d  = '0;
                  state_d = LATCH;
               end else begin
                  // Hand-over slot: a pixel here continues with no gap cycle.
                  pix_ready = 1'b1;
                  if (pix_valid) begin
                     sh_d      = pix_data;
                     bit_cnt_d = BITCNT_W'(PIXEL_W - 1);
                     last_d    = pix_last;
                  end else begin
                     urun_d  = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
         end
         LATCH: begin
            if (lcnt_q == (lat_q - LATCH_W'(1))) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               lcnt_d = lcnt_q + LATCH_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         sh_q      <= '0;
         bit_cnt_q <= '0;
         last_q    <= 1'b0;
         t0h_q     <= '0;
         t1h_q     <= '0;
         per_q     <= CNT_W'(2);
         lat_q     <= LATCH_W'(1);
         lcnt_q    <= '0;
         led_q     <= 1'b0;
         done_q    <= 1'b0;
         urun_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         bit_cnt_q <= bit_cnt_d;
         last_q    <= last_d;
         t0h_q     <= t0h_d;
         t1h_q     <= t1h_d;
         per_q     <= per_d;
         lat_q     <= lat_d;
         lcnt_q    <= lcnt_d;
         led_q     <= led_d;
         done_q    <= done_d;
         urun_q    <= urun_d;
      end
   end

   assign led_dout   = led_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;
   assign underrun   = urun_q;

endmodule

// File: doc/string_led_serializer.md
# string_led_serializer

Serializes a stream of 24-bit GRB pixels into the single-wire NRZ waveform that drives a WS2812-class LED string. It is the last stage of the string LED controller: it takes pixels from the Wishbone-fed pixel path and drives the user-project pin that leaves the chip on `mprj_io`. Per-bit high times, bit period and latch (reset) gap are runtime-configurable in `wb_clk_i` cycles.

## Interface
- `CNT_W`, default 8: width of the bit-timing counter and of `cfg_t0h`, `cfg_t1h` and `cfg_period`.
- `LATCH_W`, default 16: width of the latch-gap counter and of `cfg_latch`.
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `cfg_t0h` in CNT_W: high time of a 0 bit, in cycles.
- `cfg_t1h` in CNT_W: high time of a 1 bit, in cycles.
- `cfg_period` in CNT_W: total bit period, in cycles.
- `cfg_latch` in LATCH_W: low gap emitted after a frame, in cycles.
- `pix_valid` in 1: pixel offered.
- `pix_ready` out 1: pixel accepted when both `pix_valid` and `pix_ready` are high.
- `pix_data` in 24: pixel bits, sent MSB first (bit 23 first).
- `pix_last` in 1: marks the last pixel of a frame; qualified by the handshake.
- `led_dout` out 1: registered serial output to the pad.
- `busy` out 1: high in any state other than IDLE.
- `frame_done` out 1: one-cycle pulse when the latch gap ends.
- `underrun` out 1: one-cycle pulse when the stream starves mid-frame.

## Operation
- **Reset values:**
  - `led_dout`, `busy`, `frame_done` and `underrun` are 0.
  - `pix_ready` is 1.
  - The state is IDLE.
- **Config capture:** `cfg_*` is sampled into shadow registers only on an IDLE-state handshake. It is held for the whole frame, so mid-frame changes are ignored.
- **Clamps, applied at capture:**
  - Effective period P = max(`cfg_period`, 2).
  - Effective latch L = max(`cfg_latch`, 1).
  - A high time ≥ P gives an all-high bit; a high time of 0 gives an all-low bit.
- **IDLE:**
  - `pix_ready` = 1 and `led_dout` = 0.
  - On handshake: load the shift register, set `bit_cnt` = 23 and `cnt` = 0, latch `pix_last` into `last_q`, and go to BIT.
- **BIT:**
  - `cnt` counts from 0 to P−1.
  - Next `led_dout` = (`cnt` < TH), where TH = `sh[23]` ? t1h : t0h.
  - At `cnt` = P−1 with `bit_cnt` > 0: shift left, decrement `bit_cnt`, and clear `cnt`.
  - At `cnt` = P−1 with `bit_cnt` = 0:
    - If `last_q` = 1: go to LATCH.
    - Else, if a handshake occurs in this cycle: load the new pixel and stay in BIT with no gap.
    - Else: pulse `underrun` and go to IDLE.
- **`pix_ready` in BIT:** high only in the cycle where `cnt` = P−1, `bit_cnt` = 0 and `last_q` = 0. It is 0 in every other BIT cycle and in LATCH.
- **LATCH:**
  - `led_dout` = 0 for L cycles.
  - In the final cycle, pulse `frame_done` (registered, so it is high in the cycle the state returns to IDLE).
  - Then go to IDLE.
- **Reset mid-operation:** the block returns to IDLE immediately and `led_dout` drops to 0 asynchronously. A partial pixel is discarded.

## Timing
- **Latency:** `led_dout` first rises one cycle after the IDLE handshake.
- **Bit length:** each bit lasts exactly P cycles on `led_dout`.
- **Back-to-back pixels:** pixels handed over in the `pix_ready` slot continue with zero idle cycles between bit 0 of one pixel and bit 23 of the next.
- **Frame length:** one pixel occupies 24·P cycles. A frame of N pixels ends with an L-cycle low gap, and `frame_done` is high in the cycle following it.
- **Underrun:**
  - `led_dout` stays low after the last bit.
  - A later handshake in IDLE restarts transmission.
  - The downstream string latches only if the gap exceeds its own reset time; the block does not enforce this.

## Structure
- **Package `string_led_pkg` holds:**
  - the state enum (IDLE, BIT, LATCH);
  - `PIXEL_W` = 24;
  - default timing constants for a 40 MHz clock: `T0H_DEF` = 14, `T1H_DEF` = 28, `PERIOD_DEF` = 50, `LATCH_DEF` = 12000.
- **Sub-module `string_led_bit_timer`:**
  - Contains the `cnt` counter, the end-of-period strobe and the `cnt` < TH compare.
  - The FSM, shift register and handshake stay in the top level.

## Test plan
All scenarios use t0h = 4, t1h = 8, P = 12, L = 50 unless stated otherwise.
- **Single pixel:** `pix_data` = 0xA50000 with `pix_last` = 1.
  - `led_dout` shows 24 bit periods of 12 cycles each, with high widths 8,4,8,4,4,8,4,8 followed by sixteen 4s.
  - This is followed by 50 low cycles, then a 1-cycle `frame_done`.
- **Three-pixel frame with continuous `pix_valid`:** 72 consecutive bit periods, no gap cycles, `pix_ready` high exactly once per pixel after the first, and `frame_done` pulsed once.
- **Starved stream:** the second pixel is withheld.
  - `underrun` pulses at the end of bit 0 of the first pixel and `busy` falls.
  - Supplying the pixel 100 cycles later restarts output one cycle after the handshake.
- **Config change mid-frame:** `cfg_t1h` is set to 10 during pixel 1. All 1 bits of the frame stay 8 cycles wide; the next frame uses 10.
- **Degenerate config:** `cfg_period` = 0, `cfg_t1h` = 5, `cfg_latch` = 0 gives 2-cycle bits (1 bits all-high) and a 1-cycle latch.
- **Reset asserted during bit 10:** `led_dout`, `busy` and `frame_done` go to 0 immediately and `pix_ready` = 1. A new pixel after release transmits normally.
